lockstep_voter: RTL and testbench



---
 rtl/lockstep_pkg.sv | 17 +
 rtl/lockstep_maj3.sv | 19 +
 rtl/lockstep_voter.sv | 122 ++++++++++++
 tb/tb_lockstep_voter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lockstep_pkg.sv
// Shared types and VGA bundle layout for the lockstep checker/voter.
package lockstep_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_SUSPECT = 2'b01,
    ST_FAULT   = 2'b10
  } lockstep_state_t;

  localparam int VGA_BUNDLE_W  = 43;
  localparam int HRDATA_LSB    = 0;
  localparam int HREADYOUT_BIT = 32;
  localparam int HSYNC_BIT     = 33;
  localparam int VSYNC_BIT     = 34;
  localparam int RGB_LSB       = 35;

endpackage

// File: rtl/lockstep_maj3.sv
// Bitwise 3-input majority vote plus per-input disagreement flags.
// Purely combinational.
module lockstep_maj3 #(
  parameter int WIDTH = 43
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] maj,
  output logic [2:0]       flags
);

  assign maj = (a & b) | (a & c) | (b & c);

  assign flags[0] = |(a ^ maj);
  assign flags[1] = |(b ^ maj);
  assign flags[2] = |(c ^ maj);

endmodule

// File: rtl/lockstep_voter.sv
// N-way (2 or 3) lockstep checker/voter: combinational vote, registered mismatch flags,
// persistence-filtered sticky fault FSM and a saturating mismatch counter.
module lockstep_voter
  import lockstep_pkg::*;
#(
  parameter int WIDTH   = VGA_BUNDLE_W,
  parameter int NREP    = 3,
  parameter int PERSIST = 2,
  parameter int CNT_W   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [NREP*WIDTH-1:0] rep_in,
  input  logic [WIDTH-1:0]      inject_bug,
  input  logic                  clear_err,
  output logic [WIDTH-1:0]      voted_out,
  output logic [NREP-1:0]       mismatch_vec,
  output logic                  DLS_ERROR,
  output logic [1:0]            fault_state,
  output logic [CNT_W-1:0]      err_count
);

  if (NREP != 2 && NREP != 3) begin : g_bad_nrep
    $error("lockstep_voter: NREP must be 2 or 3");
  end
  if (PERSIST < 1 || PERSIST > 15) begin : g_bad_persist
    $error("lockstep_voter: PERSIST must be in 1..15");
  end

  localparam logic [3:0]       PERSIST_L = 4'(PERSIST);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [WIDTH-1:0] rep [NREP];
  logic [WIDTH-1:0] voted;
  logic [NREP-1:0]  flags;
  logic             mis;

  lockstep_state_t  state;
  logic [3:0]       run;

  for (genvar i = 0; i < NREP; i++) begin : g_rep
    if (i == 1) begin : g_inj
      assign rep[i] = rep_in[i*WIDTH +: WIDTH] ^ inject_bug;
    end else begin : g_pass
      assign rep[i] = rep_in[i*WIDTH +: WIDTH];
    end
  end

  if (NREP == 3) begin : g_tmr
    lockstep_maj3 #(.WIDTH(WIDTH)) u_maj3 (
      .a     (rep[0]),
      .b     (rep[1]),
      .c     (rep[2]),
      .maj   (voted),
      .flags (flags)
    );
  end else begin : g_dls
    // Dual lockstep cannot tell which side is wrong, so both are blamed.
    assign voted = rep[0];
    assign flags = {NREP{rep[0] != rep[1]}};
  end

  assign mis         = |flags;
  assign voted_out   = voted;
  assign fault_state = state;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state        <= ST_OK;
      run          <= 4'd0;
      DLS_ERROR    <= 1'b0;
      err_count    <= '0;
      mismatch_vec <= '0;
    end else begin
      mismatch_vec <= flags;
      if (clear_err) begin
        state     <= ST_OK;
        run       <= 4'd0;
        DLS_ERROR <= 1'b0;
        err_count <= '0;
      end else begin
        if (mis && err_count != CNT_MAX) begin
          err_count <= err_count + CNT_W'(1);
        end
        case (state)
          ST_OK: begin
            if (mis) begin
              run <= 4'd1;
              if (PERSIST == 1) begin
                state     <= ST_FAULT;
                DLS_ERROR <= 1'b1;
              end else begin
                state <= ST_SUSPECT;
              end
            end
          end
          ST_SUSPECT: begin
            if (mis) begin
              run <= run + 4'd1;
              if ((run + 4'd1) >= PERSIST_L) begin
                state     <= ST_FAULT;
                DLS_ERROR <= 1'b1;
              end
            end else begin
              run   <= 4'd0;
              state <= ST_OK;
            end
          end
          ST_FAULT: begin
            DLS_ERROR <= 1'b1;
          end
          default: begin
            state     <= ST_OK;
            run       <= 4'd0;
            DLS_ERROR <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lockstep_voter.sv
// Scoreboard bench: TMR instance (PERSIST=2) and dual-lockstep instance (PERSIST=1).
module tb_lockstep_voter;

  localparam int W = 43;
  localparam logic [W-1:0] V  = 43'h123_4567_89AB;
  localparam logic [W-1:0] WB = 43'h123_4567_8900;
  localparam logic [W-1:0] HS = 43'h002_0000_0000;
  localparam logic [W-1:0] RG = 43'h7F8_0000_0000;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] r0, r1, r2, inj, a2, b2, inj2;
  logic clr, clr2;

  logic [W-1:0] voted3, voted2;
  logic [2:0]   mv3;
  logic [1:0]   mv2, st3, st2;
  logic         dls3, dls2;
  logic [7:0]   cnt3, cnt2;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [W-1:0] v;
    logic [2:0]   mv;
    logic         dls;
    logic [1:0]   st;
    logic [7:0]   cnt;
    bit           on3;
    logic [W-1:0] v2;
    logic [1:0]   mv2;
    logic         dls2;
    logic [1:0]   st2;
    logic [7:0]   cnt2;
    bit           on2;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  lockstep_voter #(.WIDTH(W), .NREP(3), .PERSIST(2), .CNT_W(8)) dut3 (
    .HCLK(clk), .HRESET(rst), .rep_in({r2, r1, r0}), .inject_bug(inj),
    .clear_err(clr), .voted_out(voted3), .mismatch_vec(mv3), .DLS_ERROR(dls3),
    .fault_state(st3), .err_count(cnt3)
  );

  lockstep_voter #(.WIDTH(W), .NREP(2), .PERSIST(1), .CNT_W(8)) dut2 (
    .HCLK(clk), .HRESET(rst), .rep_in({b2, a2}), .inject_bug(inj2),
    .clear_err(clr2), .voted_out(voted2), .mismatch_vec(mv2), .DLS_ERROR(dls2),
    .fault_state(st2), .err_count(cnt2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of TMR stimulus; expected registered values are those after the closing edge.
  task automatic drive3(input logic [W-1:0] x0, x1, x2, xi, input logic xc,
                        input logic [W-1:0] ev, input logic [2:0] emv,
                        input logic edls, input logic [1:0] est, input logic [7:0] ecnt);
    exp_t e;
    @(posedge clk);
    #2;
    r0 = x0; r1 = x1; r2 = x2; inj = xi; clr = xc;
    e = '{v: ev, mv: emv, dls: edls, st: est, cnt: ecnt, on3: 1'b1,
          v2: '0, mv2: '0, dls2: 1'b0, st2: '0, cnt2: '0, on2: 1'b0};
    q.push_back(e);
  endtask

  task automatic drive2(input logic [W-1:0] xa, xb,
                        input logic [W-1:0] ev, input logic [1:0] emv,
                        input logic edls, input logic [1:0] est, input logic [7:0] ecnt);
    exp_t e;
    @(posedge clk);
    #2;
    a2 = xa; b2 = xb;
    e = '{v: '0, mv: '0, dls: 1'b0, st: '0, cnt: '0, on3: 1'b0,
          v2: ev, mv2: emv, dls2: edls, st2: est, cnt2: ecnt, on2: 1'b1};
    q.push_back(e);
  endtask

  // Monitor: vote checked mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q[0];
        if (e.on3) chk("voted3", 64'(voted3), 64'(e.v));
        if (e.on2) chk("voted2", 64'(voted2), 64'(e.v2));
        @(posedge clk);
        #1;
        if (e.on3) begin
          chk("mismatch_vec3", 64'(mv3), 64'(e.mv));
          chk("dls_error3", 64'(dls3), 64'(e.dls));
          chk("state3", 64'(st3), 64'(e.st));
          chk("err_count3", 64'(cnt3), 64'(e.cnt));
        end
        if (e.on2) begin
          chk("mismatch_vec2", 64'(mv2), 64'(e.mv2));
          chk("dls_error2", 64'(dls2), 64'(e.dls2));
          chk("state2", 64'(st2), 64'(e.st2));
          chk("err_count2", 64'(cnt2), 64'(e.cnt2));
        end
        void'(q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    r0 = V; r1 = V; r2 = V; inj = '0; clr = 1'b0;
    a2 = V; b2 = V; inj2 = '0; clr2 = 1'b0;
    #12;
    chk("reset_voted3", 64'(voted3), 64'(V));
    chk("reset_mv3", 64'(mv3), 64'd0);
    chk("reset_dls3", 64'(dls3), 64'd0);
    chk("reset_state3", 64'(st3), 64'd0);
    chk("reset_cnt3", 64'(cnt3), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) drive3(V, V, V, '0, 1'b0, V, 3'b000, 1'b0, 2'b00, 8'd0);

    // single-cycle glitch on replica 1 is masked by the vote
    drive3(V, V, V, 43'h1, 1'b0, V, 3'b010, 1'b0, 2'b01, 8'd1);
    drive3(V, V, V, '0,    1'b0, V, 3'b000, 1'b0, 2'b00, 8'd1);

    drive3(V, V, V, '0, 1'b1, V, 3'b000, 1'b0, 2'b00, 8'd0);
    drive3(V, V, V, HS, 1'b0, V, 3'b010, 1'b0, 2'b01, 8'd1);
    drive3(V, V, V, HS, 1'b0, V, 3'b010, 1'b1, 2'b10, 8'd2);
    drive3(V, V, V, '0, 1'b0, V, 3'b000, 1'b1, 2'b10, 8'd2);
    drive3(V, V, V, '0, 1'b0, V, 3'b000, 1'b1, 2'b10, 8'd2);
    drive3(V, V, V, '0, 1'b1, V, 3'b000, 1'b0, 2'b00, 8'd0);
    drive3(V, V, V, 43'h1, 1'b0, V, 3'b010, 1'b0, 2'b01, 8'd1);
    drive3(V, V, V, '0,    1'b0, V, 3'b000, 1'b0, 2'b00, 8'd1);

    // replica 2 stuck low byte: counter saturates without wrapping
    drive3(WB, WB, WB, '0, 1'b1, WB, 3'b000, 1'b0, 2'b00, 8'd0);
    for (int k = 1; k <= 300; k++) begin
      drive3(WB, WB, WB | 43'hFF, '0, 1'b0, WB, 3'b100,
             (k >= 2), (k >= 2) ? 2'b10 : 2'b01, (k >= 255) ? 8'd255 : 8'(k));
    end

    // clear beats a coincident mismatch
    drive3(WB, WB, WB | 43'hFF, '0, 1'b1, WB, 3'b100, 1'b0, 2'b00, 8'd0);
    drive3(WB, WB, WB | 43'hFF, '0, 1'b0, WB, 3'b100, 1'b0, 2'b01, 8'd1);

    // asynchronous reset mid-SUSPECT
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_mv3", 64'(mv3), 64'd0);
    chk("async_rst_dls3", 64'(dls3), 64'd0);
    chk("async_rst_state3", 64'(st3), 64'd0);
    chk("async_rst_cnt3", 64'(cnt3), 64'd0);
    r2 = WB;
    @(negedge clk);
    rst = 1'b0;

    drive3(WB, WB, WB, '0, 1'b0, WB, 3'b000, 1'b0, 2'b00, 8'd0);
    drive3(WB, WB, WB | 43'hFF, '0, 1'b0, WB, 3'b100, 1'b0, 2'b01, 8'd1);
    drive3(WB, WB, WB | 43'hFF, '0, 1'b0, WB, 3'b100, 1'b1, 2'b10, 8'd2);
    // two replicas each disagree in a different bit: both flagged, vote keeps the base
    drive3(WB | 43'h1, WB | 43'h2, WB, '0, 1'b0, WB, 3'b011, 1'b1, 2'b10, 8'd3);
    drive3(WB, WB, WB, '0, 1'b0, WB, 3'b000, 1'b1, 2'b10, 8'd3);

    // dual lockstep, PERSIST=1
    drive2(V, V,      V, 2'b00, 1'b0, 2'b00, 8'd0);
    drive2(V, V ^ RG, V, 2'b11, 1'b1, 2'b10, 8'd1);
    drive2(V, V,      V, 2'b00, 1'b1, 2'b10, 8'd1);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) chk("scoreboard_drain", 64'(q.size()), 64'd0);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
